// File: rtl/pixel_fetch_module.sv
// Pixel fetch stage: turns sync-stage timing into framebuffer reads and expands RGB332 pixels to 24-bit colour.
// A double-buffered bank bit only changes at the frame boundary, driven by a four-phase swap handshake.
module pixel_fetch_module #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FB_W     = 160
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  HPOS,
    input  logic [9:0]  VPOS,
    input  logic        RGB_ENA,
    input  logic        HSYNC_IN,
    input  logic        VSYNC_IN,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [7:0]  MEM_DATA,
    input  logic [7:0]  BG_COLOR,
    input  logic        SWAP_REQ,
    output logic        SWAP_ACK,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        HSYNC_OUT,
    output logic        VSYNC_OUT,
    output logic        BLANK_N
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } swap_state_t;

    localparam logic [9:0]  H_ACTIVE_L = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_L = 10'(V_ACTIVE);
    localparam logic [14:0] FB_W_L     = 15'(FB_W);

    function automatic logic [7:0] expand_r(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6]};
    endfunction

    function automatic logic [7:0] expand_g(input logic [7:0] c);
        return {c[4:2], c[4:2], c[4:3]};
    endfunction

    function automatic logic [7:0] expand_b(input logic [7:0] c);
        return {c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    swap_state_t state_r;
    swap_state_t state_next_s;
    logic        bank_r;
    logic        bank_toggle_s;
    logic        swap_ack_r;

    logic [3:0]  ena_pipe_r;
    logic [3:0]  hs_pipe_r;
    logic [3:0]  vs_pipe_r;
    logic [2:0]  range_pipe_r;
    logic [1:0]  rd_pipe_r;
    logic [15:0] mem_addr_r;
    logic        mem_rd_r;
    logic [7:0]  hold_r;
    logic [7:0]  r_r;
    logic [7:0]  g_r;
    logic [7:0]  b_r;

    logic        in_range_s;
    logic        frame_bound_s;
    logic        rd_req_s;
    logic [14:0] offset_s;
    logic [7:0]  pix_s;
    logic [7:0]  color_s;

    assign in_range_s    = (HPOS < H_ACTIVE_L) && (VPOS < V_ACTIVE_L);
    assign frame_bound_s = (VPOS == V_ACTIVE_L) && (HPOS == 10'd0);
    // A new read starts each 4-pixel group, or on the first active pixel after blanking
    assign rd_req_s      = RGB_ENA && in_range_s && ((HPOS[1:0] == 2'b00) || !ena_pipe_r[0]);
    assign offset_s      = ({7'd0, VPOS[9:2]} * FB_W_L) + {7'd0, HPOS[9:2]};
    assign pix_s         = rd_pipe_r[1] ? MEM_DATA : hold_r;
    assign color_s       = range_pipe_r[2] ? pix_s : BG_COLOR;

    // Swap FSM next-state: a request seen on a boundary cycle waits for the following boundary
    always_comb begin
        state_next_s  = state_r;
        bank_toggle_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (SWAP_REQ) state_next_s = ST_PENDING;
                else          state_next_s = ST_IDLE;
            end
            ST_PENDING: begin
                if (frame_bound_s) begin
                    state_next_s  = ST_ACK;
                    bank_toggle_s = 1'b1;
                end else begin
                    state_next_s  = ST_PENDING;
                end
            end
            ST_ACK: begin
                if (!SWAP_REQ) state_next_s = ST_IDLE;
                else           state_next_s = ST_ACK;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Swap FSM state, bank and acknowledge registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            bank_r     <= 1'b0;
            swap_ack_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            bank_r     <= bank_r ^ bank_toggle_s;
            swap_ack_r <= (state_next_s == ST_ACK);
        end
    end

    // Fetch/colour pipeline: address at n+1, data at n+3, colour out at n+4
    always_ff @(posedge CLK) begin
        if (RST) begin
            ena_pipe_r   <= 4'b0000;
            hs_pipe_r    <= 4'b1111;
            vs_pipe_r    <= 4'b1111;
            range_pipe_r <= 3'b000;
            rd_pipe_r    <= 2'b00;
            mem_addr_r   <= 16'd0;
            mem_rd_r     <= 1'b0;
            hold_r       <= 8'd0;
            r_r          <= 8'd0;
            g_r          <= 8'd0;
            b_r          <= 8'd0;
        end else begin
            ena_pipe_r   <= {ena_pipe_r[2:0], RGB_ENA};
            hs_pipe_r    <= {hs_pipe_r[2:0], HSYNC_IN};
            vs_pipe_r    <= {vs_pipe_r[2:0], VSYNC_IN};
            range_pipe_r <= {range_pipe_r[1:0], in_range_s};
            rd_pipe_r    <= {rd_pipe_r[0], mem_rd_r};
            mem_addr_r   <= {bank_r, offset_s};
            mem_rd_r     <= rd_req_s;
            hold_r       <= pix_s;
            if (ena_pipe_r[2]) begin
                r_r <= expand_r(color_s);
                g_r <= expand_g(color_s);
                b_r <= expand_b(color_s);
            end else begin
                r_r <= 8'd0;
                g_r <= 8'd0;
                b_r <= 8'd0;
            end
        end
    end

    assign MEM_ADDR  = mem_addr_r;
    assign MEM_RD    = mem_rd_r;
    assign SWAP_ACK  = swap_ack_r;
    assign R         = r_r;
    assign G         = g_r;
    assign B         = b_r;
    assign BLANK_N   = ena_pipe_r[3];
    assign HSYNC_OUT = hs_pipe_r[3];
    assign VSYNC_OUT = vs_pipe_r[3];

endmodule

// File: tb/tb_pixel_fetch_module.sv
// Directed testbench for pixel_fetch_module with a 2-cycle-latency framebuffer model.
module tb_pixel_fetch_module;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  HPOS = 10'd0;
    logic [9:0]  VPOS = 10'd0;
    logic        RGB_ENA = 1'b0;
    logic        HSYNC_IN = 1'b1;
    logic        VSYNC_IN = 1'b1;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic [7:0]  MEM_DATA;
    logic [7:0]  BG_COLOR = 8'h00;
    logic        SWAP_REQ = 1'b0;
    logic        SWAP_ACK;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        HSYNC_OUT;
    logic        VSYNC_OUT;
    logic        BLANK_N;

    int n_cmp = 0;
    int n_err = 0;

    logic        force_ff = 1'b0;
    logic        rd_d1 = 1'b0;
    logic        rd_d2 = 1'b0;
    logic [15:0] a_d1 = 16'd0;
    logic [15:0] a_d2 = 16'd0;

    pixel_fetch_module dut (
        .CLK(CLK), .RST(RST), .HPOS(HPOS), .VPOS(VPOS), .RGB_ENA(RGB_ENA),
        .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
        .MEM_DATA(MEM_DATA), .BG_COLOR(BG_COLOR), .SWAP_REQ(SWAP_REQ), .SWAP_ACK(SWAP_ACK),
        .R(R), .G(G), .B(B), .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT), .BLANK_N(BLANK_N)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        case (a[14:0])
            15'd0:   return 8'hE0;
            15'd1:   return 8'h1C;
            default: return 8'h03;
        endcase
    endfunction

    // framebuffer: data valid exactly two cycles after the read strobe, junk otherwise
    always @(posedge CLK) begin
        rd_d1 <= MEM_RD;
        a_d1  <= MEM_ADDR;
        rd_d2 <= rd_d1;
        a_d2  <= a_d1;
    end
    assign MEM_DATA = force_ff ? 8'hFF : (rd_d2 ? mem_fn(a_d2) : 8'h5A);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int h, input int v, input logic e);
        HPOS    = 10'(h);
        VPOS    = 10'(v);
        RGB_ENA = e;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(0, 0, 0);
        repeat (3) tick();
        n_cmp++;
        if ({R, G, B} !== 24'd0 || BLANK_N !== 1'b0) begin
            n_err++; $display("FAIL reset_rgb rgb=%h blank_n=%b expected 000000/0", {R, G, B}, BLANK_N);
        end
        n_cmp++;
        if ({HSYNC_OUT, VSYNC_OUT, MEM_RD, SWAP_ACK} !== 4'b1100 || MEM_ADDR !== 16'd0) begin
            n_err++; $display("FAIL reset_ctl hs,vs,rd,ack=%b addr=%h expected 1100/0000",
                              {HSYNC_OUT, VSYNC_OUT, MEM_RD, SWAP_ACK}, MEM_ADDR);
        end
        RST = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_fetch();
        logic       exp_rd;
        logic       exp_bl;
        logic [7:0] exp_r;
        logic [7:0] exp_g;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(c, 0, 1'b1);
            else       drive(0, 0, 1'b0);
            exp_rd = (c == 1) || (c == 5);
            exp_bl = (c >= 4) && (c <= 11);
            exp_r  = (c >= 4 && c <= 7)  ? 8'hFF : 8'h00;
            exp_g  = (c >= 8 && c <= 11) ? 8'hFF : 8'h00;
            n_cmp++;
            if (MEM_RD !== exp_rd) begin
                n_err++; $display("FAIL fetch_rd c=%0d got=%b exp=%b", c, MEM_RD, exp_rd);
            end
            n_cmp++;
            if (R !== exp_r || G !== exp_g || B !== 8'h00 || BLANK_N !== exp_bl) begin
                n_err++; $display("FAIL fetch_pix c=%0d rgb=%h%h%h bl=%b exp=%h%h00 bl=%b",
                                  c, R, G, B, BLANK_N, exp_r, exp_g, exp_bl);
            end
            tick();
        end
    endtask

    task automatic test_addr_bg();
        BG_COLOR = 8'hE3;
        drive(4, 5, 1'b1); tick();
        n_cmp++;
        if (MEM_ADDR !== 16'h00A1 || MEM_RD !== 1'b1) begin
            n_err++; $display("FAIL addr_4_5 addr=%h rd=%b exp=00a1/1", MEM_ADDR, MEM_RD);
        end
        drive(639, 479, 1'b1); tick();
        n_cmp++;
        if (MEM_ADDR !== 16'h4AFF || MEM_RD !== 1'b0) begin
            n_err++; $display("FAIL addr_max addr=%h rd=%b exp=4aff/0", MEM_ADDR, MEM_RD);
        end
        drive(640, 0, 1'b1); tick();
        n_cmp++;
        if (MEM_RD !== 1'b0) begin
            n_err++; $display("FAIL addr_oor_rd rd=%b exp=0", MEM_RD);
        end
        drive(0, 0, 1'b0); tick();
        n_cmp++;
        if ({R, G, B} !== 24'h0000FF) begin
            n_err++; $display("FAIL addr_pix rgb=%h exp=0000ff", {R, G, B});
        end
        tick(); tick();
        n_cmp++;
        if ({R, G, B} !== 24'hFF00FF || BLANK_N !== 1'b1) begin
            n_err++; $display("FAIL bg_color rgb=%h bl=%b exp=ff00ff/1", {R, G, B}, BLANK_N);
        end
        repeat (4) tick();
    endtask

    task automatic test_blank_sync();
        force_ff = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(c, 0, 1'b0);
            HSYNC_IN = (c == 1) ? 1'b0 : 1'b1;
            n_cmp++;
            if (HSYNC_OUT !== ((c == 5) ? 1'b0 : 1'b1) || VSYNC_OUT !== 1'b1) begin
                n_err++; $display("FAIL hsync_delay c=%0d hs=%b vs=%b exp_hs=%b", c, HSYNC_OUT, VSYNC_OUT, c != 5);
            end
            if (c >= 4) begin
                n_cmp++;
                if ({R, G, B} !== 24'd0 || BLANK_N !== 1'b0 || MEM_RD !== 1'b0) begin
                    n_err++; $display("FAIL blank c=%0d rgb=%h bl=%b rd=%b exp=0/0/0", c, {R, G, B}, BLANK_N, MEM_RD);
                end
            end
            tick();
        end
        HSYNC_IN = 1'b1;
        force_ff = 1'b0;
    endtask

    task automatic test_swap_midframe();
        SWAP_REQ = 1'b1;
        drive(5, 100, 1'b0); tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b0) begin
            n_err++; $display("FAIL swap_early ack=%b exp=0", SWAP_ACK);
        end
        drive(0, 480, 1'b0); tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b1) begin
            n_err++; $display("FAIL swap_ack ack=%b exp=1", SWAP_ACK);
        end
        drive(0, 0, 1'b1); tick();
        n_cmp++;
        if (MEM_ADDR !== 16'h8000 || MEM_RD !== 1'b1) begin
            n_err++; $display("FAIL swap_bank addr=%h rd=%b exp=8000/1", MEM_ADDR, MEM_RD);
        end
        SWAP_REQ = 1'b0;
        drive(0, 0, 1'b0); tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b0) begin
            n_err++; $display("FAIL swap_release ack=%b exp=0", SWAP_ACK);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_pending();
        SWAP_REQ = 1'b1;
        drive(8, 20, 1'b1); tick();
        drive(9, 20, 1'b1); tick();
        RST = 1'b1;
        SWAP_REQ = 1'b0;
        tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b0 || {R, G, B} !== 24'd0 || BLANK_N !== 1'b0 ||
            MEM_RD !== 1'b0 || MEM_ADDR !== 16'd0 || HSYNC_OUT !== 1'b1) begin
            n_err++; $display("FAIL rst_mid ack=%b rgb=%h bl=%b rd=%b addr=%h hs=%b exp=0/0/0/0/0/1",
                              SWAP_ACK, {R, G, B}, BLANK_N, MEM_RD, MEM_ADDR, HSYNC_OUT);
        end
        RST = 1'b0;
        drive(0, 480, 1'b0); tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b0) begin
            n_err++; $display("FAIL rst_abandon ack=%b exp=0", SWAP_ACK);
        end
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(c, 0, 1'b1);
            else       drive(0, 0, 1'b0);
            if (c == 1) begin
                n_cmp++;
                if (MEM_ADDR !== 16'h0000 || MEM_RD !== 1'b1) begin
                    n_err++; $display("FAIL rst_bank addr=%h rd=%b exp=0000/1", MEM_ADDR, MEM_RD);
                end
            end
            tick();
        end
        n_cmp++;
        if (R !== 8'hFF || BLANK_N !== 1'b1) begin
            n_err++; $display("FAIL rst_resume R=%h bl=%b exp=ff/1", R, BLANK_N);
        end
        drive(0, 0, 1'b0);
        repeat (6) tick();
    endtask

    task automatic test_swap_on_boundary();
        SWAP_REQ = 1'b1;
        drive(0, 480, 1'b0); tick();
        drive(0, 0, 1'b1); tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b0 || MEM_ADDR[15] !== 1'b0) begin
            n_err++; $display("FAIL bound_first ack=%b bank=%b exp=0/0", SWAP_ACK, MEM_ADDR[15]);
        end
        drive(0, 480, 1'b0); tick();
        n_cmp++;
        if (SWAP_ACK !== 1'b1) begin
            n_err++; $display("FAIL bound_second ack=%b exp=1", SWAP_ACK);
        end
        drive(4, 0, 1'b1); tick();
        n_cmp++;
        if (MEM_ADDR !== 16'h8001) begin
            n_err++; $display("FAIL bound_bank addr=%h exp=8001", MEM_ADDR);
        end
        SWAP_REQ = 1'b0;
        drive(0, 0, 1'b0);
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_addr_bg();
        test_blank_sync();
        test_swap_midframe();
        test_reset_pending();
        test_swap_on_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
